// File: rtl/mult_seq_pkg.sv
// Shared state encoding and defaults for the operand-entry multiplier sequencer.
// No logic. Constants only.
// No flow control.
package mult_seq_pkg;

  // 4-bit encoding is also driven onto the LEDs, so the values are fixed.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REQ_A    = 4'd1,
    WAIT_A   = 4'd2,
    ARM_B    = 4'd3,
    REQ_B    = 4'd4,
    WAIT_B   = 4'd5,
    START    = 4'd6,
    WAIT_MUL = 4'd7,
    SHOW     = 4'd8
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for already-synchronised pushbutton levels.
// Latency: rise is combinational from level against a one-cycle-old copy.
// No flow control; one pulse per rising edge, a held level gives a single pulse.
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Previous-cycle copy of the level; reset value chosen by the user so a
  // button held through reset can be treated as "already pressed".
  always_ff @(posedge clk) begin
    if (reset) level_q <= RESET_VAL;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/mult_seq_controller.sv
// Sequencer for operand entry, multiply and result display with wait-state timeout.
// Latency: press in cycle k -> loaddata in k+1; ready/done in m -> next strobe/display in m+1.
// No backpressure: events outside their wait state are dropped, never queued.
module mult_seq_controller
  import mult_seq_pkg::*;
#(
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       inputdata_ready,
  input  logic       mul_done,
  output logic       loaddata,
  output logic       opsel,
  output logic       mul_start,
  output logic       show_result,
  output logic       error,
  output logic [3:0] state_dbg
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [CNT_W-1:0] timer;
  logic             press;
  logic             timeout;
  logic             in_wait;
  logic             nxt_wait;

  // Reset value 1: a button held while reset releases is not a press.
  edge_detect #(
    .RESET_VAL(1'b1)
  ) u_enter_edge (
    .clk  (clk),
    .reset(reset),
    .level(enter),
    .rise (press)
  );

  assign in_wait  = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_MUL);
  assign nxt_wait = (state_nxt == WAIT_A) || (state_nxt == WAIT_B) || (state_nxt == WAIT_MUL);

  // Next-state decode; in wait states the awaited event beats the terminal count.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:     if (press) state_nxt = REQ_A;
      REQ_A:    state_nxt = WAIT_A;
      WAIT_A: begin
        if (inputdata_ready)        state_nxt = ARM_B;
        else if (timer == TERM_CNT) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      ARM_B:    if (press) state_nxt = REQ_B;
      REQ_B:    state_nxt = WAIT_B;
      WAIT_B: begin
        if (inputdata_ready)        state_nxt = START;
        else if (timer == TERM_CNT) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      START:    state_nxt = WAIT_MUL;
      WAIT_MUL: begin
        if (mul_done)               state_nxt = SHOW;
        else if (timer == TERM_CNT) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      SHOW:     if (press) state_nxt = REQ_A;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Wait-state timer: zeroed on entry to any wait state, counts while there.
  always_ff @(posedge clk) begin
    if (reset)                                timer <= '0;
    else if (nxt_wait && (state_nxt != state)) timer <= '0;
    else if (in_wait)                         timer <= timer + CNT_W'(1);
  end

  // Sticky error: set by a timeout, cleared only when a new run starts from IDLE.
  always_ff @(posedge clk) begin
    if (reset)                         error <= 1'b0;
    else if (timeout)                  error <= 1'b1;
    else if ((state == IDLE) && press) error <= 1'b0;
  end

  // Strobes are masked during reset so nothing fires in the reset cycle even if
  // the register still holds a request state from before.
  assign loaddata    = ~reset & ((state == REQ_A) || (state == REQ_B));
  assign mul_start   = ~reset & (state == START);
  assign opsel       = (state == ARM_B) || (state == REQ_B) || (state == WAIT_B);
  assign show_result = (state == SHOW);
  assign state_dbg   = state;

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- FSM that sequences the operand-entry multiplier datapath.
- Waits for a press of the enter pushbutton, then requests the datapath to capture operand A from the switches. On a second press it captures operand B.
- Then starts the multiplier, waits for completion, and switches the 7-segment displays to the product.
- Sits beside the datapath unit inside the top level. All datapath control strobes originate here.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles spent in any wait state before aborting to IDLE with error (>=2).
- CNT_W, $clog2(TIMEOUT_CYCLES), width of the internal timeout counter (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enter  in  1  pushbutton level, active-high, already synchronized/debounced upstream.
- inputdata_ready  in  1  one-cycle pulse from datapath: requested byte captured.
- mul_done  in  1  one-cycle pulse from multiplier: product valid.
- loaddata  out  1  one-cycle request to datapath to capture inputdata.
- opsel  out  1  operand target: 0 = A, 1 = B.
- mul_start  out  1  one-cycle multiplier start pulse.
- show_result  out  1  1 = displays show product, 0 = show entered operand.
- error  out  1  sticky timeout flag.
- state_dbg  out  4  current state encoding, for LEDs.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; timer = 0; error = 0; enter_q = 1.
  - enter_q resets to 1 so a button held through reset is not a press.
  - All strobes are 0.
- Press detection: press = enter & ~enter_q, with enter_q <= enter every cycle. A press is high exactly one cycle per rising edge of enter.
- States, 4-bit encoding: IDLE=0, REQ_A=1, WAIT_A=2, ARM_B=3, REQ_B=4, WAIT_B=5, START=6, WAIT_MUL=7, SHOW=8. Codes 9-15 are illegal and go to IDLE next cycle.
- Transitions:
  - IDLE: press -> REQ_A; error cleared on that same edge.
  - REQ_A -> WAIT_A unconditionally.
  - WAIT_A: inputdata_ready -> ARM_B.
  - ARM_B: press -> REQ_B.
  - REQ_B -> WAIT_B unconditionally.
  - WAIT_B: inputdata_ready -> START.
  - START -> WAIT_MUL unconditionally.
  - WAIT_MUL: mul_done -> SHOW.
  - SHOW: press -> REQ_A, starting a new computation.
- Outputs (Moore, decoded from state only):
  - loaddata = (REQ_A | REQ_B).
  - opsel = (ARM_B | REQ_B | WAIT_B).
  - mul_start = START.
  - show_result = SHOW.
  - state_dbg = state.
- Latency:
  - Press seen in cycle k -> loaddata high in cycle k+1, for exactly 1 cycle.
  - inputdata_ready in WAIT_B at cycle m -> mul_start high in cycle m+1.
  - mul_done at cycle p -> show_result high from p+1.
- Timeout:
  - timer clears to 0 on every edge that enters WAIT_A, WAIT_B or WAIT_MUL, and increments each cycle spent there.
  - If timer == TIMEOUT_CYCLES-1 and the awaited event is absent, next state is IDLE and error is set to 1.
  - If the awaited event arrives in the same cycle as the terminal count, the event wins and no error is flagged.
- Ignored inputs:
  - inputdata_ready and mul_done outside their wait state are ignored.
  - A press in any state other than IDLE, ARM_B or SHOW is ignored and is not queued.
- Held enter generates only one press.
- Reset mid-operation returns to IDLE within one edge. No strobe is emitted in the reset cycle or the cycle after.

Decomposition:
- Package mult_seq_pkg holds the state_t enum (4-bit, values above) and the default TIMEOUT_CYCLES constant.
- One natural sub-module, edge_detect: registered rising-edge detector with a reset value parameter. It is reused for other pushbuttons.
- FSM, timer and output decode stay in mult_seq_controller.

Test Plan:
- Reset with enter held high, release and re-press -> no loaddata until the re-press; then loaddata = 1 for 1 cycle, opsel = 0, state_dbg = 1.
- Full flow:
  - Stimulus: press; ready 3 cycles later; press; ready 2 cycles later; mul_done 8 cycles later.
  - Response: loaddata pulses with opsel 0 then 1; one mul_start; show_result = 1; state_dbg = 8.
- TIMEOUT_CYCLES = 16: press, never assert ready -> 16 cycles in WAIT_A, then IDLE with error = 1. Next press clears error and loaddata pulses.
- Simultaneous: ready asserted exactly at timer = 15 in WAIT_B -> mul_start next cycle, error stays 0.
- Spurious/held inputs:
  - ready and mul_done pulses in IDLE, and enter held 50 cycles in WAIT_A -> no state change, single press only.
  - In SHOW, a press -> REQ_A and show_result drops next cycle.
- Reset asserted during WAIT_MUL -> state_dbg = 0, all strobes 0. A later mul_done is ignored.
